// File: rtl/laser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : laser_pkg
//  Description : Shared screen geometry, colour constants and datapath state
//                encoding for the laser-tower datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package laser_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    localparam logic [2:0] BLACK        = 3'b000;
    localparam logic [2:0] LASER_COLOUR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETUP    = 2'd1,
        ST_LINE     = 2'd2,
        ST_COOLDOWN = 2'd3
    } dp_state_t;

endpackage
`default_nettype wire

// File: rtl/datapath_laser_if.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_laser_if
//  Description : Controller strobes/feedback and pixel stream between the
//                laser-tower control FSM and its datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
interface datapath_laser_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7
);
    logic [X_W-1:0] tower_x;
    logic [Y_W-1:0] tower_y;
    logic [X_W-1:0] car_x;
    logic [Y_W-1:0] car_y;
    logic           draw_laser;
    logic           erase;
    logic           delay;
    logic [X_W-1:0] x_out;
    logic [Y_W-1:0] y_out;
    logic [2:0]     colour_out;
    logic           plot;
    logic           draw_done;
    logic           erase_done;
    logic           delay_done;
    logic           drawn;

    modport master (
        output tower_x, tower_y, car_x, car_y, draw_laser, erase, delay,
        input  x_out, y_out, colour_out, plot, draw_done, erase_done, delay_done, drawn
    );

    modport slave (
        input  tower_x, tower_y, car_x, car_y, draw_laser, erase, delay,
        output x_out, y_out, colour_out, plot, draw_done, erase_done, delay_done, drawn
    );

endinterface
`default_nettype wire

// File: rtl/line_rasterizer.sv
`default_nettype none
// ============================================================================
//  Module      : line_rasterizer
//  Description : Bresenham line engine; loads its terms on start, then emits
//                one pixel per cycle from (x0,y0) to (x1,y1) inclusive.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_rasterizer #(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y1,
    input  logic [2:0]     colour,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [2:0]     colour_out,
    output logic           plot,
    output logic           last
);
    import laser_pkg::*;

    localparam int D_W = ((X_W > Y_W) ? X_W : Y_W) + 1;
    localparam int E_W = D_W + 1;

    logic                  r_busy;
    logic [X_W-1:0]        r_x, r_x1;
    logic [Y_W-1:0]        r_y, r_y1;
    logic [2:0]            r_colour;
    logic signed [D_W-1:0] r_dx, r_dy;
    logic signed [E_W-1:0] r_err;
    logic                  r_sx_neg, r_sy_neg;

    logic signed [D_W-1:0] w_ddx, w_ddy, w_adx, w_ndy;
    logic signed [E_W:0]   w_e2, w_dx_ext, w_dy_ext;
    logic signed [E_W-1:0] w_err_next;
    logic                  w_step_x, w_step_y, w_last;

    assign w_ddx = $signed(D_W'(x1)) - $signed(D_W'(x0));
    assign w_ddy = $signed(D_W'(y1)) - $signed(D_W'(y0));
    assign w_adx = w_ddx[D_W-1] ? -w_ddx : w_ddx;
    // dy is carried as the negated magnitude so both step tests are plain compares
    assign w_ndy = w_ddy[D_W-1] ? w_ddy : -w_ddy;

    assign w_e2     = {r_err, 1'b0};
    assign w_dx_ext = {{2{r_dx[D_W-1]}}, r_dx};
    assign w_dy_ext = {{2{r_dy[D_W-1]}}, r_dy};
    assign w_step_x = (w_e2 >= w_dy_ext);
    assign w_step_y = (w_e2 <= w_dx_ext);
    assign w_err_next = r_err
                      + (w_step_x ? {r_dy[D_W-1], r_dy} : '0)
                      + (w_step_y ? {r_dx[D_W-1], r_dx} : '0);

    assign w_last = r_busy && (r_x == r_x1) && (r_y == r_y1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_colour <= BLACK;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_x      <= x0;
            r_y      <= y0;
            r_x1     <= x1;
            r_y1     <= y1;
            r_colour <= colour;
            r_dx     <= w_adx;
            r_dy     <= w_ndy;
            r_err    <= {w_adx[D_W-1], w_adx} + {w_ndy[D_W-1], w_ndy};
            r_sx_neg <= w_ddx[D_W-1];
            r_sy_neg <= w_ddy[D_W-1];
        end else if (r_busy) begin
            if (w_last) begin
                r_busy <= 1'b0;
            end else begin
                r_err <= w_err_next;
                if (w_step_x) r_x <= r_sx_neg ? r_x - X_W'(1) : r_x + X_W'(1);
                if (w_step_y) r_y <= r_sy_neg ? r_y - Y_W'(1) : r_y + Y_W'(1);
            end
        end
    end

    assign x          = r_x;
    assign y          = r_y;
    assign colour_out = r_busy ? r_colour : BLACK;
    assign plot       = r_busy;
    assign last       = w_last;

endmodule
`default_nettype wire

// File: rtl/datapath_laser.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_laser
//  Description : Laser-tower datapath: strobe decode, endpoint latch, drawn
//                flag, cooldown counter and the line rasterizer.
//                Option macro LASER_PULSE_EN alternates the drawn colour.
//  Revision    : 1.0 - initial release
// ============================================================================
module datapath_laser #(
    parameter int          X_W          = laser_pkg::X_W,
    parameter int          Y_W          = laser_pkg::Y_W,
    parameter logic [24:0] DELAY_CYCLES = 25'd5_000_000,
    parameter logic [2:0]  LASER_COLOUR = laser_pkg::LASER_COLOUR
) (
    input  logic                clk,
    input  logic                reset,
    datapath_laser_if.slave     bus
);
    import laser_pkg::*;

    dp_state_t      r_state;
    logic [X_W-1:0] r_ex;
    logic [Y_W-1:0] r_ey;
    logic [2:0]     r_colour;
    logic           r_op_erase;
    logic           r_drawn;
    logic [24:0]    r_cnt;

    logic           w_start, w_in_line, w_last;
    logic           w_draw_done, w_erase_done, w_delay_done, w_cnt_final;
    logic [2:0]     w_draw_colour;

`ifdef LASER_PULSE_EN
    logic r_pulse;

    always_ff @(posedge clk) begin
        if (reset)            r_pulse <= 1'b0;
        else if (w_draw_done) r_pulse <= ~r_pulse;
    end

    assign w_draw_colour = r_pulse ? ~LASER_COLOUR : LASER_COLOUR;
`else
    assign w_draw_colour = LASER_COLOUR;
`endif

    assign w_start      = (r_state == ST_SETUP);
    assign w_in_line    = (r_state == ST_LINE);
    assign w_draw_done  = w_in_line && w_last && !r_op_erase;
    assign w_erase_done = w_in_line && w_last &&  r_op_erase;
    assign w_cnt_final  = (r_cnt == DELAY_CYCLES - 25'd1);
    assign w_delay_done = (r_state == ST_COOLDOWN) && bus.delay && w_cnt_final;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ex       <= bus.tower_x;
            r_ey       <= bus.tower_y;
            r_colour   <= BLACK;
            r_op_erase <= 1'b0;
            r_drawn    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_draw_done)       r_drawn <= 1'b1;
            else if (w_erase_done) r_drawn <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // erase keeps the stored endpoint so it retraces the last line
                    if (bus.erase) begin
                        r_op_erase <= 1'b1;
                        r_colour   <= BLACK;
                        r_state    <= ST_SETUP;
                    end else if (bus.draw_laser) begin
                        r_op_erase <= 1'b0;
                        r_ex       <= bus.car_x;
                        r_ey       <= bus.car_y;
                        r_colour   <= w_draw_colour;
                        r_state    <= ST_SETUP;
                    end else if (bus.delay) begin
                        r_cnt   <= '0;
                        r_state <= ST_COOLDOWN;
                    end
                end
                ST_SETUP: r_state <= ST_LINE;
                ST_LINE: begin
                    if (w_last) r_state <= ST_IDLE;
                end
                ST_COOLDOWN: begin
                    if (!bus.delay || w_cnt_final) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 25'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    line_rasterizer #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_line (
        .clk        (clk),
        .reset      (reset),
        .start      (w_start),
        .x0         (bus.tower_x),
        .y0         (bus.tower_y),
        .x1         (r_ex),
        .y1         (r_ey),
        .colour     (r_colour),
        .x          (bus.x_out),
        .y          (bus.y_out),
        .colour_out (bus.colour_out),
        .plot       (bus.plot),
        .last       (w_last)
    );

    assign bus.draw_done  = w_draw_done;
    assign bus.erase_done = w_erase_done;
    assign bus.delay_done = w_delay_done;
    assign bus.drawn      = r_drawn;

endmodule
`default_nettype wire

// File: tb/tb_datapath_laser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datapath_laser
//  Description : Directed plus randomised bench for datapath_laser against a
//                pixel-list reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_laser;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    datapath_laser_if #(.X_W(8), .Y_W(7)) bus ();

    datapath_laser #(
        .X_W          (8),
        .Y_W          (7),
        .DELAY_CYCLES (25'd4),
        .LASER_COLOUR (3'b100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // reference state: stored endpoint, drawn flag, completed draws since reset
    int ref_ex, ref_ey, ref_draws;
    bit ref_drawn;
    int exp_x[$];
    int exp_y[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] draw_colour_model();
`ifdef LASER_PULSE_EN
        return (ref_draws % 2 == 1) ? 3'b011 : 3'b100;
`else
        return 3'b100;
`endif
    endfunction

    // textbook Bresenham producing the full pixel list
    task automatic build_line(input int x0, input int y0, input int x1, input int y1);
        int dx, dy, sx, sy, err, e2, x, y;
        exp_x.delete();
        exp_y.delete();
        dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy  = (y1 > y0) ? y0 - y1 : y1 - y0;
        sx  = (x0 < x1) ? 1 : -1;
        sy  = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x   = x0;
        y   = y0;
        forever begin
            exp_x.push_back(x);
            exp_y.push_back(y);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic model_reset();
        ref_ex    = int'(bus.tower_x);
        ref_ey    = int'(bus.tower_y);
        ref_drawn = 1'b0;
        ref_draws = 0;
    endtask

    // change_at: pixel index at which car moves; abort_at: pixel index at which reset is raised
    task automatic run_line(input bit is_erase, input int change_at, input int abort_at);
        int n;
        logic [2:0] col;
        bit last;
        if (!is_erase) begin
            ref_ex = int'(bus.car_x);
            ref_ey = int'(bus.car_y);
        end
        build_line(int'(bus.tower_x), int'(bus.tower_y), ref_ex, ref_ey);
        n   = exp_x.size();
        col = is_erase ? 3'b000 : draw_colour_model();

        @(negedge clk);
        bus.draw_laser = !is_erase;
        bus.erase      = is_erase;
        @(negedge clk);
        chk("setup_plot", bus.plot, 0);

        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            last = (i == n - 1);
            if (i == change_at) begin
                bus.car_x = 8'($urandom_range(0, 159));
                bus.car_y = 7'($urandom_range(0, 119));
            end
            chk("line_plot", bus.plot, 1);
            chk("line_x", bus.x_out, exp_x[i]);
            chk("line_y", bus.y_out, exp_y[i]);
            chk("line_colour", bus.colour_out, col);
            chk("draw_done", bus.draw_done, (!is_erase && last) ? 1 : 0);
            chk("erase_done", bus.erase_done, (is_erase && last) ? 1 : 0);
            chk("drawn_during", bus.drawn, ref_drawn);
            if (i == abort_at) begin
                reset          = 1'b1;
                bus.draw_laser = 1'b0;
                bus.erase      = 1'b0;
                @(negedge clk);
                chk("abort_plot", bus.plot, 0);
                chk("abort_draw_done", bus.draw_done, 0);
                chk("abort_erase_done", bus.erase_done, 0);
                chk("abort_delay_done", bus.delay_done, 0);
                chk("abort_drawn", bus.drawn, 0);
                reset = 1'b0;
                model_reset();
                return;
            end
            if (last) begin
                bus.draw_laser = 1'b0;
                bus.erase      = 1'b0;
            end
        end

        if (is_erase) begin
            ref_drawn = 1'b0;
        end else begin
            ref_drawn = 1'b1;
            ref_draws++;
        end
        @(negedge clk);
        chk("after_plot", bus.plot, 0);
        chk("after_drawn", bus.drawn, ref_drawn);
        chk("after_done", bus.draw_done | bus.erase_done, 0);
    endtask

    // hold delay for up to hold cycles of cooldown; done expected on the 4th
    task automatic run_delay(input int hold);
        @(negedge clk);
        bus.delay = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("delay_done", bus.delay_done, (hold >= 4 && c == 4) ? 1 : 0);
            chk("delay_plot", bus.plot, 0);
            if (c == hold || c == 4) begin
                bus.delay = 1'b0;
                break;
            end
        end
        repeat (5) begin
            @(negedge clk);
            chk("delay_quiet", bus.delay_done, 0);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.draw_laser = 1'b0;
        bus.erase      = 1'b0;
        bus.delay      = 1'b0;
        bus.tower_x    = 8'd10;
        bus.tower_y    = 7'd10;
        bus.car_x      = 8'd14;
        bus.car_y      = 7'd10;
        repeat (2) @(negedge clk);
        chk("rst_plot", bus.plot, 0);
        chk("rst_x", bus.x_out, 0);
        chk("rst_y", bus.y_out, 0);
        chk("rst_colour", bus.colour_out, 0);
        chk("rst_dones", {bus.draw_done, bus.erase_done, bus.delay_done}, 0);
        chk("rst_drawn", bus.drawn, 0);
        reset = 1'b0;
        model_reset();

        // horizontal draw, then erase after the car has moved
        run_line(1'b0, -1, -1);
        bus.car_x = 8'd50;
        bus.car_y = 7'd50;
        run_line(1'b1, -1, -1);

        // steep diagonal (second draw exercises the colour alternation)
        bus.tower_x = 8'd20;
        bus.tower_y = 7'd5;
        bus.car_x   = 8'd22;
        bus.car_y   = 7'd11;
        run_line(1'b0, -1, -1);
        run_line(1'b1, -1, -1);

        // random lines, car moved while the line is being drawn
        for (int k = 0; k < 8; k++) begin
            bus.tower_x = 8'($urandom_range(0, 159));
            bus.tower_y = 7'($urandom_range(0, 119));
            if (k == 0) begin
                bus.car_x = bus.tower_x;
                bus.car_y = bus.tower_y;
            end else begin
                bus.car_x = 8'($urandom_range(0, 159));
                bus.car_y = 7'($urandom_range(0, 119));
            end
            run_line(1'b0, int'($urandom_range(0, 3)), -1);
            run_line(1'b1, int'($urandom_range(0, 3)), -1);
        end

        // cooldown: full, aborted, full again (counter must restart)
        run_delay(4);
        run_delay(2);
        run_delay(4);

        // reset during the third pixel of a line
        bus.tower_x = 8'd30;
        bus.tower_y = 7'd40;
        bus.car_x   = 8'd40;
        bus.car_y   = 7'd45;
        run_line(1'b0, -1, -1);
        bus.car_x = 8'd45;
        bus.car_y = 7'd30;
        run_line(1'b0, -1, 2);

        // erase with nothing drawn: one black pixel at the tower
        run_line(1'b1, -1, -1);
        bus.car_x = 8'd33;
        bus.car_y = 7'd41;
        run_line(1'b0, -1, -1);
        run_line(1'b0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
